piso_shift_register: RTL and testbench

Parallel-in, serial-out shift register. It is the transmit-side counterpart of the lab's serial-in shift register. A WIDTH-bit word is accepted over a valid/ready handshake and shifted out MSB first, one bit per clk. A serial-in register that shifts in at its LSB therefore holds the original word exactly WIDTH cycles after the first bit appears. Back-to-back words stream with no bubble cycles.

---
 rtl/piso_shift_register_pkg.sv | 17 +
 rtl/piso_shift_register.sv | 84 ++++++++
 tb/tb_piso_shift_register.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_shift_register_pkg.sv
// Shared types and helpers for the parallel-in, serial-out shift register.
// Holds the FSM state encoding and the bit-counter width function.
// No logic lives here; it is imported by the block that needs it.
package piso_shift_register_pkg;

   // IDLE waits for a word, SHIFT drives one bit per clk.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Counter width for a WIDTH-bit word; never narrower than one bit.
   function automatic int clog2(input int value);
      return (value < 2) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register: loads a WIDTH-bit word, emits it MSB first.
// Latency: din[WIDTH-1-k] appears on serial_out k cycles after the loading edge.
// Backpressure: din_ready only in IDLE or on the last bit, so words stream with no bubbles.
module piso_shift_register
   import piso_shift_register_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             last
);

   localparam int            CW       = clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             in_shift;
   logic             xfer;

   // Outputs are decoded straight from state so reset clears them without waiting for clk.
   assign in_shift     = (state_q == SHIFT);
   assign last         = in_shift && (cnt_q == CNT_LAST);
   assign serial_valid = in_shift;
   assign serial_out   = in_shift & shreg_q[WIDTH-1];
   assign din_ready    = !rst && (!in_shift || last);
   assign xfer         = din_valid && din_ready;

   // Next-state: load on handshake, shift otherwise, drop to IDLE after an unfollowed last bit.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (xfer) begin
               shreg_d = din;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (!last) begin
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               cnt_d   = cnt_q + CW'(1);
            end else if (xfer) begin
               // Reload on the final bit of the previous word for back-to-back streaming.
               shreg_d = din;
               cnt_d   = '0;
            end else begin
               shreg_d = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset discards any partially shifted word immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: directed patterns plus randomized loopback traffic.
// Expected outputs come from a queue holding the bits still to be transmitted.
// A serial-in shift register model receives the stream and reassembles each word.
module tb_piso_shift_register;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         din_ready;
   logic         serial_out;
   logic         serial_valid;
   logic         last;
   logic [3:0]   obs;
   logic [W-1:0] rx_q;

   int total;
   int bad;

   // Bits the block still owes; front is the bit that should be on serial_out now.
   bit exp_q[$];

   piso_shift_register #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .last         (last)
   );

   assign obs = {din_ready, serial_valid, serial_out, last};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Loopback receiver: serial-in shift register, shifting in at the LSB.
   always @(posedge clk) begin
      if (serial_valid) rx_q <= {rx_q[W-2:0], serial_out};
   end

   // Expected {din_ready, serial_valid, serial_out, last} with rst low.
   function automatic logic [3:0] exp_vec();
      if (exp_q.size() == 0) return 4'b1000;
      return {exp_q.size() == 1, 1'b1, exp_q[0], exp_q.size() == 1};
   endfunction

   // Present inputs for one edge, clock it, and advance the reference model.
   task automatic advance(input logic v, input logic [W-1:0] d, output logic took);
      logic rdy;
      din_valid = v;
      din       = d;
      rdy       = (exp_q.size() <= 1);
      took      = v && rdy;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (took) begin
         for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
      end
   endtask

   task automatic test_reset();
      logic t;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (obs !== 4'b0000) begin
         bad++;
         $display("FAIL reset_hold: got %b want %b", obs, 4'b0000);
      end
      rst = 1'b0;
      #1;
      total++;
      if (obs !== exp_vec()) begin
         bad++;
         $display("FAIL reset_release: got %b want %b", obs, exp_vec());
      end
      advance(1'b1, 4'b1010, t);
      advance(1'b0, 4'b0000, t);
      total++;
      if (obs !== exp_vec()) begin
         bad++;
         $display("FAIL pre_reset_stream: got %b want %b", obs, exp_vec());
      end
      rst = 1'b1;
      exp_q.delete();
      #1;
      total++;
      if (obs !== 4'b0000) begin
         bad++;
         $display("FAIL reset_async: got %b want %b", obs, 4'b0000);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_held[%0d]: got %b want %b", i, obs, 4'b0000);
         end
      end
      rst = 1'b0;
      #1;
      total++;
      if (obs !== exp_vec() || din_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_after_release: got %b want %b", obs, exp_vec());
      end
   endtask

   task automatic test_single_word();
      logic       t;
      logic [3:0] pat;
      pat = 4'b1011;
      advance(1'b1, pat, t);
      for (int k = 0; k < 4; k++) begin
         total++;
         if (obs !== exp_vec() || serial_out !== pat[3-k] || last !== (k == 3)) begin
            bad++;
            $display("FAIL single_word[%0d]: got %b want %b bit %b", k, obs, exp_vec(), pat[3-k]);
         end
         advance(1'b0, 4'b0000, t);
      end
      total++;
      if (obs !== 4'b1000) begin
         bad++;
         $display("FAIL single_word_idle: got %b want %b", obs, 4'b1000);
      end
   endtask

   task automatic test_back_to_back();
      logic       t;
      logic [7:0] seq;
      seq = 8'b1100_0110;
      advance(1'b1, 4'b1100, t);
      for (int k = 0; k < 8; k++) begin
         total++;
         if (obs !== exp_vec() || serial_out !== seq[7-k] || serial_valid !== 1'b1
             || din_ready !== (k == 3 || k == 7)) begin
            bad++;
            $display("FAIL back_to_back[%0d]: got %b want %b bit %b", k, obs, exp_vec(), seq[7-k]);
         end
         advance(k <= 3, (k < 3) ? 4'b1100 : 4'b0110, t);
      end
      total++;
      if (obs !== 4'b1000) begin
         bad++;
         $display("FAIL back_to_back_idle: got %b want %b", obs, 4'b1000);
      end
   endtask

   task automatic test_backpressure();
      logic       t;
      logic [7:0] seq;
      logic       v;
      logic [W-1:0] d;
      seq = 8'b1001_0110;
      advance(1'b1, 4'b1001, t);
      for (int k = 0; k < 8; k++) begin
         total++;
         if (obs !== exp_vec() || serial_out !== seq[7-k]) begin
            bad++;
            $display("FAIL backpressure[%0d]: got %b want %b bit %b", k, obs, exp_vec(), seq[7-k]);
         end
         case (k)
            0:       begin v = 1'b0; d = 4'b0000; end
            1, 2:    begin v = 1'b1; d = W'($urandom); end
            3:       begin v = 1'b1; d = 4'b0110; end
            default: begin v = 1'b0; d = W'($urandom); end
         endcase
         advance(v, d, t);
      end
      total++;
      if (obs !== 4'b1000) begin
         bad++;
         $display("FAIL backpressure_idle: got %b want %b", obs, 4'b1000);
      end
   endtask

   task automatic test_reset_mid_word();
      logic       t;
      logic [3:0] pat;
      advance(1'b1, 4'b1111, t);
      advance(1'b0, 4'b0000, t);
      advance(1'b0, 4'b0000, t);
      rst = 1'b1;
      exp_q.delete();
      #1;
      total++;
      if (obs !== 4'b0000) begin
         bad++;
         $display("FAIL mid_word_async: got %b want %b", obs, 4'b0000);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      total++;
      if (obs !== 4'b1000) begin
         bad++;
         $display("FAIL mid_word_release: got %b want %b", obs, 4'b1000);
      end
      pat = 4'b0001;
      advance(1'b1, pat, t);
      for (int k = 0; k < 4; k++) begin
         total++;
         if (obs !== exp_vec() || serial_out !== pat[3-k]) begin
            bad++;
            $display("FAIL mid_word_next[%0d]: got %b want %b bit %b", k, obs, exp_vec(), pat[3-k]);
         end
         advance(1'b0, 4'b0000, t);
      end
   endtask

   task automatic test_loopback();
      logic         t;
      logic         v;
      logic         was_last;
      logic [W-1:0] d;
      logic [W-1:0] want;
      logic [W-1:0] words[$];
      int           sent;
      int           got;
      int           cyc;
      sent = 0;
      got  = 0;
      cyc  = 0;
      while ((sent < 16 || exp_q.size() > 0) && cyc < 400) begin
         v        = (sent < 16) && ($urandom_range(0, 3) != 0);
         d        = W'($urandom);
         was_last = (exp_q.size() == 1);
         advance(v, d, t);
         cyc++;
         if (was_last) begin
            want = words.pop_front();
            got++;
            total++;
            if (rx_q !== want) begin
               bad++;
               $display("FAIL loopback_word[%0d]: got %b want %b", got - 1, rx_q, want);
            end
         end
         if (t) begin
            words.push_back(d);
            sent++;
         end
         total++;
         if (obs !== exp_vec()) begin
            bad++;
            $display("FAIL loopback_cycle[%0d]: got %b want %b", cyc, obs, exp_vec());
         end
      end
      total++;
      if (got != 16) begin
         bad++;
         $display("FAIL loopback_count: got %0d want %0d", got, 16);
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      din       = '0;
      din_valid = 1'b0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_word();
      test_loopback();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
